neuron_mac: RTL

- Single-neuron multiply-accumulate stage that sits directly downstream of a per-neuron weight memory (W_Mem_x_y family).
- Accepts one activation per cycle, issues the matching weight read (ren/radd) to the weight memory, and aligns the 1-cycle registered weight with the delayed activation.
- Accumulates NUM_WEIGHT fixed-point products, adds a bias, saturates to DATA_WIDTH and presents one result with a single-cycle valid pulse to the activation stage.

---
 rtl/neuron_mac.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Single-neuron fixed-point MAC: streams NUM_WEIGHT activations against a registered
// weight memory, adds a bias, saturates, and emits one result with a one-cycle valid pulse.
module neuron_mac #(
    parameter int NUM_WEIGHT = 30,
    parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 12,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         w_ren,
    output logic        [ADDR_WIDTH-1:0] w_radd,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         busy
);

    // The counter must be able to hold NUM_WEIGHT itself, which may need one bit more than the address.
    localparam int CNT_WIDTH  = $clog2(NUM_WEIGHT + 1);
    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_BIAS,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic        [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] act_q, act_d;
    logic                         vld_q, vld_d;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic                         out_valid_q, out_valid_d;

    logic                         accept;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [PROD_WIDTH-1:0] prod_sh;
    logic signed [ACC_WIDTH-1:0]  sum;

    assign in_ready  = (state_q == S_IDLE) ||
                       ((state_q == S_ACCUM) && (cnt_q < CNT_WIDTH'(NUM_WEIGHT)));
    assign accept    = in_valid && in_ready;
    assign w_ren     = accept;
    assign w_radd    = ADDR_WIDTH'(cnt_q);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_q;
    assign out_valid = out_valid_q;

    // act_q is the activation accepted one edge ago; w_data is the weight read at that same edge.
    assign prod    = PROD_WIDTH'(act_q) * PROD_WIDTH'(w_data);
    assign prod_sh = prod >>> FRAC_BITS;
    assign sum     = acc_q + ACC_WIDTH'(bias);

    always_comb begin
        // NOTE: every _d takes a default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_d       = act_q;
        vld_d       = 1'b0;
        out_d       = out_q;
        out_valid_d = 1'b0;

        if (vld_q) begin
            acc_d = acc_q + ACC_WIDTH'(prod_sh);
        end

        if (accept) begin
            act_d = in_data;
            cnt_d = cnt_q + CNT_WIDTH'(1);
            vld_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    state_d = (cnt_d == CNT_WIDTH'(NUM_WEIGHT)) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && (cnt_d == CNT_WIDTH'(NUM_WEIGHT))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_BIAS;
            end
            S_BIAS: begin
                if (sum > ACC_SAT_MAX) begin
                    out_d = OUT_MAX;
                end else if (sum < ACC_SAT_MIN) begin
                    out_d = OUT_MIN;
                end else begin
                    out_d = sum[DATA_WIDTH-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            act_q       <= '0;
            vld_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_q       <= act_d;
            vld_q       <= vld_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
